// File: rtl/circ_msg_fetcher.sv
// circ_msg_fetcher: bursts circulant rows from banked RAMs through per-bank rotation to a stream, and writes returned rows back un-rotated
module circ_msg_fetcher #(
  parameter int NUM_BANKS     = 9,
  parameter int ADDR_WIDTH    = 3,
  parameter int MSG_WIDTH     = 6,
  parameter int LOG2CIRC_SIZE = 2
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  start,
  input  logic [ADDR_WIDTH-1:0]                                 base_addr,
  input  logic [ADDR_WIDTH:0]                                   burst_len,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0]                       addr_off_vec,
  input  logic [NUM_BANKS*LOG2CIRC_SIZE-1:0]                    shift_vec,
  input  logic                                                  vr_process,
  output logic                                                  busy,
  output logic                                                  done,
  output logic                                                  ram_rd_en,
  output logic [NUM_BANKS*ADDR_WIDTH-1:0]                       ram_rd_addr,
  input  logic [NUM_BANKS*(2**LOG2CIRC_SIZE)*MSG_WIDTH-1:0]     ram_rd_data,
  output logic                                                  m_valid,
  input  logic                                                  m_ready,
  output logic [NUM_BANKS*(2**LOG2CIRC_SIZE)*MSG_WIDTH-1:0]     m_data,
  output logic                                                  m_last,
  input  logic                                                  s_valid,
  output logic                                                  s_ready,
  input  logic [NUM_BANKS*(2**LOG2CIRC_SIZE)*MSG_WIDTH-1:0]     s_data,
  output logic                                                  ram_wr_en,
  output logic [NUM_BANKS*ADDR_WIDTH-1:0]                       ram_wr_addr,
  output logic [NUM_BANKS*(2**LOG2CIRC_SIZE)*MSG_WIDTH-1:0]     ram_wr_data
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CIRC  = 2 ** LOG2CIRC_SIZE;
  localparam int BUS   = CIRC * MSG_WIDTH;
  localparam int RW    = NUM_BANKS * BUS;
  localparam int AV    = NUM_BANKS * ADDR_WIDTH;
  localparam int SV    = NUM_BANKS * LOG2CIRC_SIZE;
  localparam int CW    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state, state_nx;
  logic [ADDR_WIDTH-1:0]  base;
  logic [CW-1:0]          len, len_in, rd_cnt, wr_cnt, out_cnt;
  logic [AV-1:0]          off, rd_addr_all, wr_addr_all;
  logic [SV-1:0]          shift;
  logic                   vr, inflight, wptr, rptr, push, pop, acc;
  logic [1:0]             fifo_cnt;
  logic [RW-1:0]          mem [2];
  logic [RW-1:0]          rot_rd, rot_wr;

  // fwd: out lane j = in lane (j+s); otherwise (j-s); both mod CIRC via truncation
  function automatic logic [BUS-1:0] rot(input logic [BUS-1:0] w, input logic [LOG2CIRC_SIZE-1:0] s, input logic fwd);
    logic [LOG2CIRC_SIZE-1:0] k;
    rot = '0;
    for (int j = 0; j < CIRC; j++) begin
      k = fwd ? LOG2CIRC_SIZE'(j) + s : LOG2CIRC_SIZE'(j) - s;
      rot[j*MSG_WIDTH +: MSG_WIDTH] = w[k*MSG_WIDTH +: MSG_WIDTH];
    end
  endfunction

  always_comb begin
    rot_rd      = '0;
    rot_wr      = '0;
    rd_addr_all = '0;
    wr_addr_all = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      rot_rd[b*BUS +: BUS]             = rot(ram_rd_data[b*BUS +: BUS], shift[b*LOG2CIRC_SIZE +: LOG2CIRC_SIZE], vr);
      rot_wr[b*BUS +: BUS]             = rot(s_data[b*BUS +: BUS], shift[b*LOG2CIRC_SIZE +: LOG2CIRC_SIZE], !vr);
      rd_addr_all[b*ADDR_WIDTH +: ADDR_WIDTH] = base + off[b*ADDR_WIDTH +: ADDR_WIDTH] + rd_cnt[ADDR_WIDTH-1:0];
      wr_addr_all[b*ADDR_WIDTH +: ADDR_WIDTH] = base + off[b*ADDR_WIDTH +: ADDR_WIDTH] + wr_cnt[ADDR_WIDTH-1:0];
    end
  end

  assign len_in      = burst_len > CW'(DEPTH) ? CW'(DEPTH) : burst_len;
  // reads in flight count against FIFO space so at most two rows are ever pending
  assign ram_rd_en   = state == RUN && rd_cnt < len && (3'(fifo_cnt) + 3'(inflight)) < 3'd2;
  assign ram_rd_addr = ram_rd_en ? rd_addr_all : '0;
  assign m_valid     = fifo_cnt != 2'd0;
  assign m_data      = mem[rptr];
  assign m_last      = m_valid && out_cnt == len - CW'(1);
  assign pop         = m_valid && m_ready;
  assign push        = inflight;
  assign s_ready     = (state == RUN || state == DRAIN) && wr_cnt < len;
  assign acc         = s_valid && s_ready;
  assign busy        = state != IDLE;
  assign done        = state == DONE;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? (len_in == '0 ? DONE : RUN) : IDLE;
      RUN:     state_nx = rd_cnt == len ? DRAIN : RUN;
      DRAIN:   state_nx = (fifo_cnt == 2'd0 && !inflight && wr_cnt == len) ? DONE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      base        <= '0;
      len         <= '0;
      off         <= '0;
      shift       <= '0;
      vr          <= 1'b0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      out_cnt     <= '0;
      inflight    <= 1'b0;
      wptr        <= 1'b0;
      rptr        <= 1'b0;
      fifo_cnt    <= '0;
      mem[0]      <= '0;
      mem[1]      <= '0;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        base    <= base_addr;
        len     <= len_in;
        off     <= addr_off_vec;
        shift   <= shift_vec;
        vr      <= vr_process;
        rd_cnt  <= '0;
        wr_cnt  <= '0;
        out_cnt <= '0;
      end
      if (ram_rd_en) rd_cnt <= rd_cnt + CW'(1);
      inflight <= ram_rd_en;
      if (push) begin
        mem[wptr] <= rot_rd;
        wptr      <= ~wptr;
      end
      if (pop) begin
        rptr    <= ~rptr;
        out_cnt <= out_cnt + CW'(1);
      end
      fifo_cnt  <= fifo_cnt + 2'(push) - 2'(pop);
      ram_wr_en <= acc;
      if (acc) begin
        ram_wr_addr <= wr_addr_all;
        ram_wr_data <= rot_wr;
        wr_cnt      <= wr_cnt + CW'(1);
      end
    end
  end
endmodule
